// File: rtl/pico_port_decoder.sv
// Port decoder between the KCPSM6 port bus and N peripheral channels.
// Channel/sub-register address map, strobes, read mux and interrupt aggregation.
module pico_port_decoder #(
    parameter int N_CH     = 4,
    parameter int SUB_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            port_id,
    input  logic [7:0]            out_port,
    input  logic                  write_strobe,
    input  logic                  read_strobe,
    output logic [7:0]            in_port,
    output logic                  interrupt,
    input  logic                  interrupt_ack,
    output logic [N_CH-1:0]       ch_wr,
    output logic [N_CH-1:0]       ch_rd,
    output logic [N_CH-1:0]       ch_act,
    output logic [SUB_BITS-1:0]   ch_addr,
    output logic [7:0]            ch_wdata,
    input  logic [8*N_CH-1:0]     ch_rdata,
    input  logic [N_CH-1:0]       ch_irq
);

    localparam int CH_BITS = 8 - SUB_BITS;

    logic [CH_BITS-1:0]  ch;
    logic [SUB_BITS-1:0] sub;
    logic [N_CH-1:0]     sel_oh;
    logic [7:0]          rd_mux;
    logic                valid;
    logic                is_ctrl;
    logic                mask_we;
    logic                pend_w1c;
    logic [N_CH-1:0]     pm;
    logic [N_CH-1:0]     ack_oh;
    logic [CH_BITS-1:0]  ack_idx;
    logic                ack_hit;

    logic [7:0]          in_port_q, in_port_d;
    logic                interrupt_q, interrupt_d;
    logic [N_CH-1:0]     ch_wr_q, ch_wr_d;
    logic [N_CH-1:0]     ch_rd_q, ch_rd_d;
    logic [N_CH-1:0]     ch_act_q, ch_act_d;
    logic [SUB_BITS-1:0] ch_addr_q, ch_addr_d;
    logic [7:0]          ch_wdata_q, ch_wdata_d;
    logic [N_CH-1:0]     mask_q, mask_d;
    logic [N_CH-1:0]     pend_q, pend_d;
    logic [CH_BITS-1:0]  vect_q, vect_d;
    logic [N_CH-1:0]     irq_q, irq_d;

    always_comb begin
        ch     = port_id[7:SUB_BITS];
        sub    = port_id[SUB_BITS-1:0];
        sel_oh = '0;
        rd_mux = 8'h00;
        for (int k = 0; k < N_CH; k++) begin
            if (ch == CH_BITS'(k)) begin
                sel_oh[k] = 1'b1;
                rd_mux    = ch_rdata[8*k +: 8];
            end
        end
        valid    = |sel_oh;
        is_ctrl  = &ch;
        mask_we  = write_strobe && is_ctrl && (sub == SUB_BITS'(0));
        pend_w1c = write_strobe && is_ctrl && (sub == SUB_BITS'(1));
    end

    // Lowest-index pending-and-enabled channel wins the acknowledge.
    always_comb begin
        pm      = pend_q & mask_q;
        ack_oh  = '0;
        ack_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (pm[k]) begin
                ack_oh    = '0;
                ack_oh[k] = 1'b1;
                ack_idx   = CH_BITS'(k);
            end
        end
        ack_hit = interrupt_ack && (|pm);
    end

    always_comb begin
        in_port_d   = 8'h00;
        interrupt_d = |pm;
        ch_wr_d     = '0;
        ch_rd_d     = '0;
        ch_act_d    = ch_act_q;
        ch_addr_d   = ch_addr_q;
        ch_wdata_d  = ch_wdata_q;
        mask_d      = mask_q;
        vect_d      = vect_q;
        irq_d       = ch_irq;

        unique case (1'b1)
            valid:
                in_port_d = rd_mux;
            is_ctrl && (sub == SUB_BITS'(0)):
                in_port_d = 8'(mask_q);
            is_ctrl && (sub == SUB_BITS'(1)):
                in_port_d = 8'(pend_q);
            is_ctrl && (sub == SUB_BITS'(2)):
                in_port_d = 8'(vect_q);
            default:
                in_port_d = 8'h00;
        endcase

        if (valid && write_strobe) begin
            ch_wr_d    = sel_oh;
            ch_wdata_d = out_port;
        end
        if (valid && read_strobe) begin
            ch_rd_d = sel_oh;
        end
        if (valid && (write_strobe || read_strobe)) begin
            ch_act_d  = sel_oh;
            ch_addr_d = sub;
        end

        if (mask_we) begin
            mask_d = N_CH'(out_port);
        end
        if (ack_hit) begin
            vect_d = ack_idx;
        end

        // New edges are OR-ed in last so a same-cycle set beats any clear.
        pend_d = pend_q;
        if (pend_w1c) begin
            pend_d = pend_d & ~N_CH'(out_port);
        end
        if (ack_hit) begin
            pend_d = pend_d & ~ack_oh;
        end
        pend_d = pend_d | (ch_irq & ~irq_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_port_q   <= '0;
            interrupt_q <= 1'b0;
            ch_wr_q     <= '0;
            ch_rd_q     <= '0;
            ch_act_q    <= '0;
            ch_addr_q   <= '0;
            ch_wdata_q  <= '0;
            mask_q      <= '0;
            pend_q      <= '0;
            vect_q      <= '0;
            irq_q       <= '0;
        end else begin
            in_port_q   <= in_port_d;
            interrupt_q <= interrupt_d;
            ch_wr_q     <= ch_wr_d;
            ch_rd_q     <= ch_rd_d;
            ch_act_q    <= ch_act_d;
            ch_addr_q   <= ch_addr_d;
            ch_wdata_q  <= ch_wdata_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            vect_q      <= vect_d;
            irq_q       <= irq_d;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = interrupt_q;
    assign ch_wr     = ch_wr_q;
    assign ch_rd     = ch_rd_q;
    assign ch_act    = ch_act_q;
    assign ch_addr   = ch_addr_q;
    assign ch_wdata  = ch_wdata_q;

endmodule

// File: tb/tb_pico_port_decoder.sv
// Scoreboard bench for pico_port_decoder: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_pico_port_decoder;

    localparam int N_CH = 4;
    localparam int SB   = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [7:0]        port_id;
    logic [7:0]        out_port;
    logic              write_strobe;
    logic              read_strobe;
    logic [7:0]        in_port;
    logic              interrupt;
    logic              interrupt_ack;
    logic [N_CH-1:0]   ch_wr;
    logic [N_CH-1:0]   ch_rd;
    logic [N_CH-1:0]   ch_act;
    logic [SB-1:0]     ch_addr;
    logic [7:0]        ch_wdata;
    logic [8*N_CH-1:0] ch_rdata;
    logic [N_CH-1:0]   ch_irq;

    pico_port_decoder #(.N_CH(N_CH), .SUB_BITS(SB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .in_port      (in_port),
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack),
        .ch_wr        (ch_wr),
        .ch_rd        (ch_rd),
        .ch_act       (ch_act),
        .ch_addr      (ch_addr),
        .ch_wdata     (ch_wdata),
        .ch_rdata     (ch_rdata),
        .ch_irq       (ch_irq)
    );

    always #5 clk = ~clk;

    localparam int S_INP = 0;
    localparam int S_IRQ = 1;
    localparam int S_WR  = 2;
    localparam int S_RD  = 3;
    localparam int S_ACT = 4;
    localparam int S_ADR = 5;
    localparam int S_WD  = 6;

    typedef struct {
        int         due;
        string      name;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   tests  = 0;
    int   failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] observe(int sel);
        case (sel)
            S_INP:   return in_port;
            S_IRQ:   return {7'd0, interrupt};
            S_WR:    return {4'd0, ch_wr};
            S_RD:    return {4'd0, ch_rd};
            S_ACT:   return {4'd0, ch_act};
            S_ADR:   return {4'd0, ch_addr};
            default: return ch_wdata;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due <= cyc) begin
                logic [7:0] obs;
                obs = observe(sbq[i].sel);
                tests++;
                if (sbq[i].due < cyc) begin
                    failed++;
                    $display("FAIL %s: missed check due cycle %0d", sbq[i].name, sbq[i].due);
                end else if (obs !== sbq[i].val) begin
                    failed++;
                    $display("FAIL %s: cycle %0d got 0x%02h expected 0x%02h",
                             sbq[i].name, cyc, obs, sbq[i].val);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expv(input string n, input int sel, input logic [7:0] v, input int dly);
        exp_t e;
        e.due  = cyc + dly;
        e.name = n;
        e.sel  = sel;
        e.val  = v;
        sbq.push_back(e);
    endtask

    initial begin
        reset_n       = 1'b0;
        port_id       = 8'h00;
        out_port      = 8'h00;
        write_strobe  = 1'b0;
        read_strobe   = 1'b0;
        interrupt_ack = 1'b0;
        ch_irq        = '0;
        ch_rdata      = {8'h44, 8'h5C, 8'h22, 8'h11};

        step(); step();
        expv("rst_in_port", S_INP, 8'h00, 0);
        expv("rst_irq",     S_IRQ, 8'h00, 0);
        expv("rst_wr",      S_WR,  8'h00, 0);
        expv("rst_rd",      S_RD,  8'h00, 0);
        expv("rst_act",     S_ACT, 8'h00, 0);
        expv("rst_addr",    S_ADR, 8'h00, 0);
        expv("rst_wdata",   S_WD,  8'h00, 0);
        reset_n = 1'b1;
        step();

        // write 0xA5 to port 0x13
        port_id = 8'h13; out_port = 8'hA5; write_strobe = 1'b1;
        expv("wr_pulse", S_WR,  8'h02, 1);
        expv("wr_addr",  S_ADR, 8'h03, 1);
        expv("wr_wdata", S_WD,  8'hA5, 1);
        expv("wr_act",   S_ACT, 8'h02, 1);
        expv("wr_no_rd", S_RD,  8'h00, 1);
        step();
        write_strobe = 1'b0;
        expv("wr_once",  S_WR,  8'h00, 1);
        expv("act_hold", S_ACT, 8'h02, 1);
        expv("rd_ch1",   S_INP, 8'h22, 1);
        step();

        // read channel 2 via port 0x21
        port_id = 8'h21;
        step();
        read_strobe = 1'b1;
        expv("rd_data",  S_INP, 8'h5C, 1);
        expv("rd_pulse", S_RD,  8'h04, 1);
        expv("rd_act",   S_ACT, 8'h04, 1);
        expv("rd_addr",  S_ADR, 8'h01, 1);
        expv("rd_no_wr", S_WR,  8'h00, 1);
        step();
        read_strobe = 1'b0;
        expv("rd_once",   S_RD,  8'h00, 1);
        expv("rd_actkeep", S_ACT, 8'h04, 1);
        step();

        // unmapped port 0x70
        port_id = 8'h70; out_port = 8'h33; write_strobe = 1'b1;
        expv("un_wr",    S_WR,  8'h00, 1);
        expv("un_act",   S_ACT, 8'h04, 1);
        expv("un_addr",  S_ADR, 8'h01, 1);
        expv("un_wdata", S_WD,  8'hA5, 1);
        expv("un_inp",   S_INP, 8'h00, 1);
        step();
        write_strobe = 1'b0; read_strobe = 1'b1;
        expv("un_rd",    S_RD,  8'h00, 1);
        expv("un_inp2",  S_INP, 8'h00, 1);
        expv("un_act2",  S_ACT, 8'h04, 1);
        step();
        read_strobe = 1'b0;

        // MASK = 0x0F
        port_id = 8'hF0; out_port = 8'h0F; write_strobe = 1'b1;
        expv("ctl_no_wr",  S_WR,  8'h00, 1);
        expv("ctl_no_act", S_ACT, 8'h04, 1);
        step();
        write_strobe = 1'b0;
        expv("mask_rd", S_INP, 8'h0F, 1);
        step();

        // edges on ch_irq[3] and ch_irq[1]
        ch_irq = 4'b1010; port_id = 8'hF1;
        expv("irq_lat1",  S_IRQ, 8'h00, 1);
        expv("pend_pre",  S_INP, 8'h00, 1);
        expv("irq_lat2",  S_IRQ, 8'h01, 2);
        expv("pend_0a",   S_INP, 8'h0A, 2);
        step(); step();

        // first ack
        interrupt_ack = 1'b1;
        expv("ack1_irq",  S_IRQ, 8'h01, 1);
        expv("ack1_pre",  S_INP, 8'h0A, 1);
        step();
        interrupt_ack = 1'b0;
        expv("ack1_pend", S_INP, 8'h08, 1);
        expv("ack1_stay", S_IRQ, 8'h01, 1);
        step();
        port_id = 8'hF2;
        expv("ack1_vect", S_INP, 8'h01, 1);
        step();

        // second ack
        interrupt_ack = 1'b1;
        expv("ack2_vpre", S_INP, 8'h01, 1);
        expv("ack2_ipre", S_IRQ, 8'h01, 1);
        expv("ack2_vect", S_INP, 8'h03, 2);
        expv("ack2_irq",  S_IRQ, 8'h00, 2);
        step();
        interrupt_ack = 1'b0;
        step();
        port_id = 8'hF1; ch_irq = '0;
        expv("ack2_pend", S_INP, 8'h00, 1);
        step();

        // masked pending then enable then W1C
        port_id = 8'hF0; out_port = 8'h00; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0; ch_irq = 4'b0001; port_id = 8'hF1;
        expv("msk_pend",  S_INP, 8'h01, 2);
        expv("msk_irq",   S_IRQ, 8'h00, 2);
        step(); step();
        port_id = 8'hF0; out_port = 8'h01; write_strobe = 1'b1;
        expv("en_irq1",   S_IRQ, 8'h00, 1);
        expv("en_irq2",   S_IRQ, 8'h01, 2);
        step();
        write_strobe = 1'b0;
        step();
        port_id = 8'hF1; out_port = 8'h01; write_strobe = 1'b1;
        expv("w1c_irq1",  S_IRQ, 8'h01, 1);
        expv("w1c_irq2",  S_IRQ, 8'h00, 2);
        step();
        write_strobe = 1'b0;
        step();

        // W1C on PEND[2] colliding with a ch_irq[2] edge
        ch_irq = 4'b0101; out_port = 8'h04; write_strobe = 1'b1;
        expv("col_pre",   S_INP, 8'h00, 1);
        expv("col_pend",  S_INP, 8'h04, 2);
        expv("col_irq",   S_IRQ, 8'h00, 2);
        step();
        write_strobe = 1'b0;
        step();

        // ack with nothing enabled pending
        interrupt_ack = 1'b1;
        expv("nack_pend", S_INP, 8'h04, 2);
        step();
        interrupt_ack = 1'b0;
        step();
        port_id = 8'hF2;
        expv("nack_vect", S_INP, 8'h03, 1);
        step();

        // reset mid-operation
        port_id = 8'h05; out_port = 8'h77; write_strobe = 1'b1;
        expv("mr_wr",    S_WR, 8'h01, 1);
        step();
        write_strobe = 1'b0; read_strobe = 1'b1;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        expv("mr_rd",    S_RD,  8'h00, 1);
        expv("mr_wr0",   S_WR,  8'h00, 1);
        expv("mr_act",   S_ACT, 8'h00, 1);
        expv("mr_addr",  S_ADR, 8'h00, 1);
        expv("mr_wdata", S_WD,  8'h00, 1);
        expv("mr_inp",   S_INP, 8'h00, 1);
        expv("mr_irq",   S_IRQ, 8'h00, 1);
        step();
        read_strobe = 1'b0;
        step();
        reset_n = 1'b1; port_id = 8'hF1;
        expv("rel_wr",   S_WR,  8'h00, 1);
        expv("rel_rd",   S_RD,  8'h00, 1);
        expv("rel_pre",  S_INP, 8'h00, 1);
        expv("rel_pend", S_INP, 8'h05, 2);
        expv("rel_irq",  S_IRQ, 8'h00, 2);
        step(); step(); step();

        for (int i = 0; i < 20 && sbq.size() > 0; i++) step();
        while (sbq.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL %s: never checked, due cycle %0d", sbq[0].name, sbq[0].due);
            void'(sbq.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pico_port_decoder.md
# pico_port_decoder

Parametrised I/O port decoder between the KCPSM6 (PicoBlaze) core and N peripheral channels (RTC, VGA, keyboard, sound, …). It replaces fixed per-device enable decoding with a channel/sub-register address map. It adds registered write and read pulses, a per-channel read-data mux, a sticky active-channel indication, and a maskable, prioritised interrupt aggregator with an acknowledge-driven vector register. It sits directly on the processor port bus inside the micro wrapper.

## Interface
- N_CH, 4: number of peripheral channels, 1..2^(8-SUB_BITS)-1.
- SUB_BITS, 4: low port_id bits used as the sub-register address. The upper 8-SUB_BITS bits select the channel.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset. Single clock domain; reset is asynchronous and active-low.
- port_id  in  8  processor port address.
- out_port  in  8  processor write data.
- write_strobe  in  1  processor write strobe, one cycle.
- read_strobe  in  1  processor read strobe, one cycle.
- in_port  out  8  read data to processor.
- interrupt  out  1  interrupt request to processor.
- interrupt_ack  in  1  processor interrupt acknowledge, one cycle.
- ch_wr  out  N_CH  one-cycle write pulse per channel.
- ch_rd  out  N_CH  one-cycle read pulse per channel (pop/clear side effects).
- ch_act  out  N_CH  one-hot, last channel accessed; held until the next valid channel access.
- ch_addr  out  SUB_BITS  registered sub-register address of the last access.
- ch_wdata  out  8  registered write data.
- ch_rdata  in  8*N_CH  channel read data; channel k occupies bits [8k+7:8k].
- ch_irq  in  N_CH  synchronous interrupt requests; the rising edge is significant.

## Operation
- Decode: ch = port_id[7:SUB_BITS], sub = port_id[SUB_BITS-1:0].
  - Valid channel: ch < N_CH.
  - Control channel: CTRL = 2^(8-SUB_BITS)-1.
  - Any other value is unmapped.
- Write to valid ch:
  - ch_wr[ch] pulses.
  - ch_addr <= sub, ch_wdata <= out_port.
  - ch_act <= one-hot(ch).
- Read of valid ch:
  - ch_rd[ch] pulses.
  - ch_addr <= sub.
  - ch_act <= one-hot(ch).
- Unmapped access: no pulses; ch_act, ch_addr and ch_wdata unchanged; reads return 0x00.
- Control registers (CTRL channel, sub-address):
  - sub 0, MASK, R/W: bit k enables channel k.
  - sub 1, PEND, R, write-1-to-clear.
  - sub 2, VECT, R: index of the last acknowledged channel, zero-extended.
  - Other sub-addresses read 0x00, writes ignored.
  - Accesses to CTRL do not touch ch_act, ch_wr or ch_rd.
  - Bits of MASK/PEND at or above N_CH read 0 and are not writable.
- Pending logic:
  - irq_q registers ch_irq each cycle.
  - A rising edge (ch_irq & ~irq_q) sets PEND[k].
  - If set and clear hit the same bit in one cycle (W1C or ack), set wins.
- Interrupt: interrupt is registered as |(PEND & MASK).
- Acknowledge:
  - On interrupt_ack, the lowest-index set bit of PEND & MASK is cleared and VECT <= its index.
  - If PEND & MASK is zero at ack, VECT and PEND are unchanged.
  - interrupt stays high if other bits remain pending.
- Masking: clearing a MASK bit does not clear PEND; re-enabling the bit re-raises interrupt.

## Timing
- Reset (async assert, sync-safe deassert): in_port, interrupt, ch_wr, ch_rd, ch_act, ch_addr, ch_wdata, MASK, PEND, VECT and irq_q all go to 0.
- Write strobe in cycle T: ch_wr, ch_addr, ch_wdata and ch_act are valid in T+1. ch_wr is high for exactly one cycle.
- in_port:
  - Registered every cycle from the port_id of the previous cycle: in_port(T+1) = mux(port_id(T)).
  - This relies on KCPSM6 holding port_id two cycles before sampling.
  - Read latency is 1 cycle.
- Read strobe in T: ch_rd pulses in T+1.
- ch_irq edge in T: PEND bit set at T+1, interrupt high at T+2 (if masked in).
- interrupt_ack in T: PEND bit cleared and VECT updated at T+1. interrupt reflects the remaining pending bits at T+2.
- Simultaneous write_strobe and interrupt_ack: both take effect; register-level conflicts resolve as set-wins.
- Reset mid-operation: pending pulses are lost, with no spurious pulse after release. irq_q = 0 after reset, so a ch_irq already high at release is counted as an edge.

## Test plan
- Write 0xA5 to port 0x13 (N_CH=4) -> T+1: ch_wr=0b0010 for one cycle, ch_addr=3, ch_wdata=0xA5, ch_act=0b0010; ch_act holds after the pulse.
- ch_rdata ch2 = 0x5C, port_id=0x21 held 2 cycles with read_strobe in the second cycle -> in_port=0x5C when sampled, ch_rd=0b0100 one pulse, ch_act=0b0100.
- Access port 0x70 (unmapped) -> no pulses, ch_act unchanged, in_port=0x00.
- MASK=0x0F; rising edges on ch_irq[3] and ch_irq[1] in the same cycle -> PEND=0x0A, interrupt=1.
  - First ack -> VECT=1, PEND=0x08, interrupt stays 1.
  - Second ack -> VECT=3, PEND=0, interrupt=0.
- MASK=0x00, edge on ch_irq[0] -> PEND=0x01, interrupt=0. Write MASK=0x01 -> interrupt=1. Write 0x01 to PEND -> interrupt=0.
- W1C on PEND[2] in the same cycle as a ch_irq[2] edge -> PEND[2]=1. Assert reset_n=0 mid-sequence -> all outputs 0 immediately.
